fft_peak_tracker: RTL and testbench
===================================

Name: fft_peak_tracker

Overview:
- Sits directly downstream of the FFT peak finder and consumes its per-window peak magnitude, bin index and valid strobe.
- Confirms that a tonal peak is stable for several consecutive FFT windows before declaring a detection.
- Holds the detection while the tone persists, and releases it after repeated misses or a stream stall.
- Gives the camera-trigger logic one clean detect pulse and a steady lock level instead of raw per-window flicker.

Parameters:
- NSamples, 1024, FFT length.
- W, 33, magnitude-squared width.
- NBits, $clog2(NSamples), bin index width.
- THRESHOLD, 33'h10000000, minimum peak magnitude for a window to qualify.
- MIN_BIN, 1, lowest qualifying bin; rejects DC.
- BIN_TOL, 2, max absolute bin difference still counted as the same tone.
- CONFIRM, 3, consecutive matching windows required to lock; legal range 1..15.
- RELEASE, 2, consecutive non-matching windows that drop the lock; legal range 1..15.
- TIMEOUT, 4096, clocks without peak_valid before tracking state is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- peak  in  W  window peak magnitude
- peak_k  in  NBits  window peak bin
- peak_valid  in  1  one-cycle strobe; peak and peak_k are valid in the same cycle
- locked  out  1  level, high while a tone is locked
- lock_k  out  NBits  bin of the locked tone
- lock_mag  out  W  largest peak seen during the confirm run and the lock
- detect  out  1  one-cycle pulse on lock entry
- release  out  1  one-cycle pulse on lock exit

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port name reset. All outputs and state are registered.
- Reset values: locked=0, lock_k=0, lock_mag=0, detect=0, release=0. Internal state: cand_k=0, hit_cnt=0, miss_cnt=0, timer=0, state=IDLE.
- Qualify: a window qualifies when peak >= THRESHOLD and peak_k >= MIN_BIN.
- Match: a window matches when it qualifies and |peak_k - ref_k| <= BIN_TOL.
  - |peak_k - ref_k| is an unsigned absolute difference on NBits with no wrap, so bin 0 and bin 1023 are far apart.
  - ref_k is cand_k in CAND and lock_k in LOCK.
- Inputs are sampled only in cycles with peak_valid=1.
- IDLE:
  - Qualifying window: cand_k <= peak_k, hit_cnt <= 1, lock_mag <= peak, go to CAND.
  - If CONFIRM==1, go straight to LOCK instead; the detect rules below apply.
- CAND:
  - Match: hit_cnt++, lock_mag <= max(lock_mag, peak).
  - When hit_cnt reaches CONFIRM: go to LOCK, lock_k <= peak_k of that final window, locked <= 1, detect pulses for 1 cycle.
  - Qualifies but does not match: restart the candidate with cand_k <= peak_k, hit_cnt <= 1, lock_mag <= peak.
  - Does not qualify: go to IDLE, hit_cnt <= 0.
- LOCK:
  - Match: miss_cnt <= 0, lock_mag <= max(lock_mag, peak). lock_k does not track.
  - Non-match (either kind): miss_cnt++.
  - When miss_cnt reaches RELEASE: go to IDLE, locked <= 0, release pulses for 1 cycle.
  - lock_k and lock_mag keep their values after release until the next detect overwrites them.
- Timeout:
  - timer counts clocks since the last peak_valid whenever state != IDLE, and clears on every peak_valid.
  - When timer reaches TIMEOUT-1:
    - From CAND: go to IDLE.
    - From LOCK: go to IDLE, locked <= 0, release pulses.
  - If peak_valid and expiry fall in the same cycle, peak_valid wins: the timer clears and the window is processed normally.
- Latency: detect and release rise the clock edge after the deciding peak_valid cycle. locked changes on that same edge.
- detect and release are never high in the same cycle. Each pulse lasts exactly one cycle, even if peak_valid arrives back to back.
- Reset mid-lock: outputs drop immediately, with no release pulse.
- Counter widths: hit_cnt and miss_cnt are 4 bits and saturate. timer is $clog2(TIMEOUT) bits.

Test Plan:
- Stable tone: CONFIRM=3. Feed 3 windows of k=100 with peak=0x20000000, 0x30000000, 0x28000000 → detect pulses 1 cycle after the 3rd strobe; locked=1, lock_k=100, lock_mag=0x30000000.
- Jitter and restart:
  - Windows at k=100, 102, 99 → lock with lock_k=99.
  - Windows at k=100, 103 → no lock; the candidate restarts at 103.
- Sub-threshold and DC: peak=0x0FFFFFFF at k=50, or peak=0x40000000 at k=0 → state stays IDLE; no detect.
- Release: while locked on k=100, send 1 miss, then a match at k=101, then 2 misses → release pulses only after the final miss; locked=0; lock_k still 100.
- Timeout: lock, then hold peak_valid low for 4096 clocks → release pulse and locked=0. Repeat with peak_valid in the expiry cycle → no release.
- Async reset: assert reset mid-LOCK between clock edges → locked, detect and release are 0 immediately; release never pulses.

Source files
------------

// File: rtl/fft_peak_tracker.sv
// Peak tracker: confirms a stable FFT peak over several windows, holds the lock
// while the tone persists and drops it on repeated misses or a stalled stream.
module fft_peak_tracker #(
    parameter int           NSamples  = 1024,
    parameter int           W         = 33,
    parameter int           NBits     = $clog2(NSamples),
    parameter logic [W-1:0] THRESHOLD = 33'h10000000,
    parameter int           MIN_BIN   = 1,
    parameter int           BIN_TOL   = 2,
    parameter int           CONFIRM   = 3,
    parameter int           RELEASE   = 2,
    parameter int           TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     peak,
    input  logic [NBits-1:0] peak_k,
    input  logic             peak_valid,
    output logic             locked,
    output logic [NBits-1:0] lock_k,
    output logic [W-1:0]     lock_mag,
    output logic             detect,
    output logic             lock_release
);

    localparam int               TW        = $clog2(TIMEOUT);
    localparam logic [NBits-1:0] MIN_K     = NBits'(MIN_BIN);
    localparam logic [NBits-1:0] TOL_K     = NBits'(BIN_TOL);
    localparam logic [3:0]       CONFIRM_C = 4'(CONFIRM);
    localparam logic [3:0]       RELEASE_C = 4'(RELEASE);
    localparam logic [TW-1:0]    TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CAND, LOCK} state_t;

    state_t           state, state_nxt;
    logic [NBits-1:0] cand_k, cand_k_nxt;
    logic [3:0]       hit_cnt, hit_nxt;
    logic [3:0]       miss_cnt, miss_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic             locked_nxt, detect_nxt, release_nxt;
    logic [NBits-1:0] lock_k_nxt;
    logic [W-1:0]     lock_mag_nxt;

    logic [NBits-1:0] ref_k, diff;
    logic [W-1:0]     mag_max;
    logic [3:0]       hit_inc, miss_inc;
    logic             qualify, is_match;

    // Bin distance is a plain unsigned difference, so bins 0 and N-1 never alias.
    assign ref_k    = (state == LOCK) ? lock_k : cand_k;
    assign diff     = (peak_k >= ref_k) ? (peak_k - ref_k) : (ref_k - peak_k);
    assign qualify  = (peak >= THRESHOLD) && (peak_k >= MIN_K);
    assign is_match = qualify && (diff <= TOL_K);
    assign mag_max  = (peak > lock_mag) ? peak : lock_mag;
    assign hit_inc  = (hit_cnt == 4'hF) ? hit_cnt : hit_cnt + 4'd1;
    assign miss_inc = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cand_k       <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            timer        <= '0;
            locked       <= 1'b0;
            lock_k       <= '0;
            lock_mag     <= '0;
            detect       <= 1'b0;
            lock_release <= 1'b0;
        end else begin
            state        <= state_nxt;
            cand_k       <= cand_k_nxt;
            hit_cnt      <= hit_nxt;
            miss_cnt     <= miss_nxt;
            timer        <= timer_nxt;
            locked       <= locked_nxt;
            lock_k       <= lock_k_nxt;
            lock_mag     <= lock_mag_nxt;
            detect       <= detect_nxt;
            lock_release <= release_nxt;
        end
    end

    // A peak_valid in the expiry cycle takes priority over the stall timeout.
    always_comb begin
        state_nxt    = state;
        cand_k_nxt   = cand_k;
        hit_nxt      = hit_cnt;
        miss_nxt     = miss_cnt;
        timer_nxt    = timer;
        locked_nxt   = locked;
        lock_k_nxt   = lock_k;
        lock_mag_nxt = lock_mag;
        detect_nxt   = 1'b0;
        release_nxt  = 1'b0;

        if (peak_valid) begin
            timer_nxt = '0;
            case (state)
                IDLE: begin
                    if (qualify) begin
                        cand_k_nxt   = peak_k;
                        hit_nxt      = 4'd1;
                        lock_mag_nxt = peak;
                        if (CONFIRM == 1) begin
                            state_nxt  = LOCK;
                            lock_k_nxt = peak_k;
                            locked_nxt = 1'b1;
                            detect_nxt = 1'b1;
                            miss_nxt   = '0;
                        end else begin
                            state_nxt = CAND;
                        end
                    end
                end
                CAND: begin
                    if (is_match) begin
                        hit_nxt      = hit_inc;
                        lock_mag_nxt = mag_max;
                        if (hit_inc >= CONFIRM_C) begin
                            state_nxt  = LOCK;
                            lock_k_nxt = peak_k;
                            locked_nxt = 1'b1;
                            detect_nxt = 1'b1;
                            miss_nxt   = '0;
                        end
                    end else if (qualify) begin
                        cand_k_nxt   = peak_k;
                        hit_nxt      = 4'd1;
                        lock_mag_nxt = peak;
                    end else begin
                        state_nxt = IDLE;
                        hit_nxt   = '0;
                    end
                end
                LOCK: begin
                    if (is_match) begin
                        miss_nxt     = '0;
                        lock_mag_nxt = mag_max;
                    end else if (miss_inc >= RELEASE_C) begin
                        state_nxt   = IDLE;
                        locked_nxt  = 1'b0;
                        release_nxt = 1'b1;
                        miss_nxt    = '0;
                        hit_nxt     = '0;
                    end else begin
                        miss_nxt = miss_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (timer == TIMER_MAX) begin
                timer_nxt = '0;
                state_nxt = IDLE;
                hit_nxt   = '0;
                miss_nxt  = '0;
                if (state == LOCK) begin
                    locked_nxt  = 1'b0;
                    release_nxt = 1'b1;
                end
            end else begin
                timer_nxt = timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Bench for fft_peak_tracker: directed vector table, timeout and reset sequences,
// then random windows checked against a window-level behavioural model.
module tb_fft_peak_tracker;

    localparam logic [32:0] THR      = 33'h10000000;
    localparam int          N_VEC    = 22;
    localparam int          TIMEOUT  = 4096;
    localparam int          CONFIRM  = 3;
    localparam int          RELEASE  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] peak;
    logic [9:0]  peak_k;
    logic        peak_valid;
    logic        locked;
    logic [9:0]  lock_k;
    logic [32:0] lock_mag;
    logic        detect;
    logic        lock_release;

    int total = 0;
    int bad   = 0;

    fft_peak_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .peak         (peak),
        .peak_k       (peak_k),
        .peak_valid   (peak_valid),
        .locked       (locked),
        .lock_k       (lock_k),
        .lock_mag     (lock_mag),
        .detect       (detect),
        .lock_release (lock_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [32:0] pk;
        logic [9:0]  k;
        logic        e_locked;
        logic [9:0]  e_k;
        logic [32:0] e_mag;
        logic        e_det;
        logic        e_rel;
    } vec_t;

    vec_t tbl [N_VEC];

    // Window-level reference: tone tracking expressed as run lengths and a stall clock count.
    bit          m_locked, m_det, m_rel;
    int          m_lock_k, m_cand, m_hits, m_misses, m_stall;
    logic [32:0] m_mag;

    function automatic void model_reset();
        m_locked = 0; m_det = 0; m_rel = 0;
        m_lock_k = 0; m_cand = 0; m_hits = 0; m_misses = 0; m_stall = 0;
        m_mag = '0;
    endfunction

    function automatic int absdiff(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic void model_step(bit v, logic [32:0] pk, int k);
        bit q, tracking;
        m_det = 0;
        m_rel = 0;
        tracking = m_locked || (m_hits > 0);
        if (v) begin
            m_stall = 0;
            q = (pk >= THR) && (k >= 1);
            if (m_locked) begin
                if (q && absdiff(k, m_lock_k) <= 2) begin
                    m_misses = 0;
                    if (pk > m_mag) m_mag = pk;
                end else begin
                    m_misses = (m_misses < 15) ? m_misses + 1 : 15;
                    if (m_misses >= RELEASE) begin
                        m_locked = 0; m_rel = 1; m_misses = 0; m_hits = 0;
                    end
                end
            end else if (m_hits > 0) begin
                if (q && absdiff(k, m_cand) <= 2) begin
                    m_hits = (m_hits < 15) ? m_hits + 1 : 15;
                    if (pk > m_mag) m_mag = pk;
                    if (m_hits >= CONFIRM) begin
                        m_locked = 1; m_det = 1; m_lock_k = k; m_misses = 0;
                    end
                end else if (q) begin
                    m_cand = k; m_hits = 1; m_mag = pk;
                end else begin
                    m_hits = 0;
                end
            end else if (q) begin
                m_cand = k; m_hits = 1; m_mag = pk;
            end
        end else if (tracking) begin
            if (m_stall == TIMEOUT - 1) begin
                m_stall = 0;
                m_hits = 0;
                m_misses = 0;
                if (m_locked) begin
                    m_locked = 0; m_rel = 1;
                end
            end else begin
                m_stall++;
            end
        end
    endfunction

    // Entered and left at posedge+1: drive, let the edge sample, advance the model.
    task automatic applyStimulus(input logic v, input logic [32:0] pk, input logic [9:0] k);
        peak_valid = v;
        peak       = pk;
        peak_k     = k;
        @(posedge clk);
        model_step(v, pk, int'(k));
        #1;
    endtask

    task automatic checkOutput(input string name, input logic e_locked, input logic [9:0] e_k,
                               input logic [32:0] e_mag, input logic e_det, input logic e_rel);
        total++;
        if (locked !== e_locked || lock_k !== e_k || lock_mag !== e_mag ||
            detect !== e_det || lock_release !== e_rel) begin
            bad++;
            $display("[TB] FAIL %s: got locked=%0b lock_k=%0d lock_mag=%h detect=%0b release=%0b, expected locked=%0b lock_k=%0d lock_mag=%h detect=%0b release=%0b",
                     name, locked, lock_k, lock_mag, detect, lock_release,
                     e_locked, e_k, e_mag, e_det, e_rel);
        end
    endtask

    task automatic idleClocks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 33'h20000000, 10'd100,  1'b0, 10'd0,   33'h20000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 33'h30000000, 10'd100,  1'b0, 10'd0,   33'h30000000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 33'h28000000, 10'd100,  1'b1, 10'd100, 33'h30000000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 33'h00000000, 10'd0,    1'b1, 10'd100, 33'h30000000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 33'h20000000, 10'd200,  1'b1, 10'd100, 33'h30000000, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 33'h20000000, 10'd101,  1'b1, 10'd100, 33'h30000000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 33'h20000000, 10'd300,  1'b1, 10'd100, 33'h30000000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 33'h0FFFFFFF, 10'd100,  1'b0, 10'd100, 33'h30000000, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 33'h00000000, 10'd0,    1'b0, 10'd100, 33'h30000000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 33'h0FFFFFFF, 10'd50,   1'b0, 10'd100, 33'h30000000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 33'h40000000, 10'd0,    1'b0, 10'd100, 33'h30000000, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 33'h20000000, 10'd100,  1'b0, 10'd100, 33'h20000000, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 33'h20000000, 10'd102,  1'b0, 10'd100, 33'h20000000, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 33'h20000000, 10'd99,   1'b1, 10'd99,  33'h20000000, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 33'h20000000, 10'd500,  1'b1, 10'd99,  33'h20000000, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 33'h20000000, 10'd500,  1'b0, 10'd99,  33'h20000000, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 33'h10000000, 10'd100,  1'b0, 10'd99,  33'h10000000, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 33'h21000000, 10'd103,  1'b0, 10'd99,  33'h21000000, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 33'h20000000, 10'd104,  1'b0, 10'd99,  33'h21000000, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 33'h20000000, 10'd105,  1'b1, 10'd105, 33'h21000000, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 33'h20000000, 10'd1023, 1'b1, 10'd105, 33'h21000000, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 33'h40000000, 10'd0,    1'b0, 10'd105, 33'h21000000, 1'b0, 1'b1};

        reset = 1'b1;
        peak_valid = 1'b0;
        peak = '0;
        peak_k = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 1'b0, 10'd0, 33'h0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            applyStimulus(tbl[i].v, tbl[i].pk, tbl[i].k);
            checkOutput($sformatf("vec%0d", i), tbl[i].e_locked, tbl[i].e_k,
                        tbl[i].e_mag, tbl[i].e_det, tbl[i].e_rel);
        end

        // Stall timeout out of LOCK: release on the 4096th quiet clock.
        repeat (3) applyStimulus(1'b1, 33'h20000000, 10'd200);
        checkOutput("to_lock", 1'b1, 10'd200, 33'h20000000, 1'b1, 1'b0);
        idleClocks(TIMEOUT - 1);
        checkOutput("to_before_expiry", 1'b1, 10'd200, 33'h20000000, 1'b0, 1'b0);
        idleClocks(1);
        checkOutput("to_expiry", 1'b0, 10'd200, 33'h20000000, 1'b0, 1'b1);
        idleClocks(1);
        checkOutput("to_after", 1'b0, 10'd200, 33'h20000000, 1'b0, 1'b0);

        // Valid window landing in the expiry cycle keeps the lock and restarts the timer.
        repeat (3) applyStimulus(1'b1, 33'h20000000, 10'd200);
        checkOutput("tv_lock", 1'b1, 10'd200, 33'h20000000, 1'b1, 1'b0);
        idleClocks(TIMEOUT - 1);
        applyStimulus(1'b1, 33'h50000000, 10'd201);
        checkOutput("tv_valid_wins", 1'b1, 10'd200, 33'h50000000, 1'b0, 1'b0);
        idleClocks(TIMEOUT - 1);
        checkOutput("tv_rearmed", 1'b1, 10'd200, 33'h50000000, 1'b0, 1'b0);
        idleClocks(1);
        checkOutput("tv_expiry", 1'b0, 10'd200, 33'h50000000, 1'b0, 1'b1);

        // Asynchronous reset while detect is high: everything clears between edges.
        repeat (3) applyStimulus(1'b1, 33'h30000000, 10'd300);
        checkOutput("ar_lock", 1'b1, 10'd300, 33'h30000000, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_immediate", 1'b0, 10'd0, 33'h0, 1'b0, 1'b0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("ar_hold%0d", i), 1'b0, 10'd0, 33'h0, 1'b0, 1'b0);
        end
        reset = 1'b0;

        // Random windows clustered around a wandering tone, compared to the model.
        begin
            int base;
            int kk;
            int r;
            logic        v;
            logic [32:0] pk;
            base = 100;
            for (int n = 0; n < 800; n++) begin
                if ($urandom_range(0, 40) == 0) begin
                    case ($urandom_range(0, 3))
                        0: base = 3;
                        1: base = 100;
                        2: base = 500;
                        default: base = 1021;
                    endcase
                end
                v = ($urandom_range(0, 3) != 0);
                r = int'($urandom_range(0, 9));
                if (r < 7) begin
                    kk = base + int'($urandom_range(0, 6)) - 3;
                    if (kk < 0) kk = 0;
                    if (kk > 1023) kk = 1023;
                end else if (r == 7) begin
                    kk = int'($urandom_range(0, 1023));
                end else begin
                    kk = r - 8;
                end
                case ($urandom_range(0, 5))
                    0:       pk = 33'($urandom_range(0, 32'h0FFFFFFF));
                    1:       pk = THR;
                    default: pk = THR + 33'($urandom());
                endcase
                applyStimulus(v, pk, 10'(kk));
                checkOutput($sformatf("rand%0d", n), m_locked, 10'(m_lock_k), m_mag, m_det, m_rel);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
